// File: rtl/jk_reg_bank.sv
// Multi-bit register bank with run-time selectable JK / D / T / SR update per bit,
// plus a per-edge change mask, a sticky illegal-SR flag and a saturating transition counter.
module jk_reg_bank #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              clr_stat,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_not,
  output logic [WIDTH-1:0]  changed,
  output logic              sr_err,
  output logic [CNT_W-1:0]  toggle_cnt
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             sr_err_q, sr_err_d;
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;

  logic [PC_W-1:0]  pop_cnt;
  logic [SUM_W-1:0] cnt_sum;
  logic             sr_set;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_JK: begin
            case ({j[i], k[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_D:  q_d[i] = j[i];
          MODE_T:  q_d[i] = q_q[i] ^ j[i];
          default: begin
            // SR: the illegal 11 combination holds the bit, same as 00.
            case ({j[i], k[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              default: q_d[i] = q_q[i];
            endcase
          end
        endcase
      end
    end

    changed_d = q_d ^ q_q;

    sr_set   = en && (mode == MODE_SR) && (|(j & k));
    sr_err_d = sr_set | (sr_err_q & ~clr_stat);

    // The counter accumulates the mask registered at the previous edge, so it lags changed by one cycle.
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + PC_W'(changed_q[i]);
    end
    cnt_sum = SUM_W'(toggle_cnt_q) + SUM_W'(pop_cnt);

    if (clr_stat) begin
      toggle_cnt_d = '0;
    end else if (cnt_sum > SUM_W'(CNT_MAX)) begin
      toggle_cnt_d = CNT_MAX;
    end else begin
      toggle_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q          <= RESET_VALUE;
      changed_q    <= '0;
      sr_err_q     <= 1'b0;
      toggle_cnt_q <= '0;
    end else begin
      q_q          <= q_d;
      changed_q    <= changed_d;
      sr_err_q     <= sr_err_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  assign q          = q_q;
  assign q_not      = ~q_q;
  assign changed    = changed_q;
  assign sr_err     = sr_err_q;
  assign toggle_cnt = toggle_cnt_q;

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised multi-bit JK register bank with per-bit J/K inputs, a run-time mode select (JK, D, T, SR) and a common update enable. It also reports which bits changed on each clock edge, flags illegal SR stimulus in a sticky error bit, and keeps a saturating count of bit transitions. It replaces single-bit JK flip-flops wherever a register of flags or state bits needs JK-style set/clear/toggle control from several sources.

## Interface

**Parameters**
- `WIDTH`, default 8: number of register bits.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded into `q` on reset.
- `CNT_W`, default 16: width of the transition counter.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: update enable for `q`.
- `mode`, input, 2: 00 = JK, 01 = D, 10 = T, 11 = SR.
- `j`, input, WIDTH: per-bit J / D / T / S input.
- `k`, input, WIDTH: per-bit K / R input; ignored in D and T modes.
- `clr_stat`, input, 1: clears `sr_err` and `toggle_cnt`.
- `q`, output, WIDTH, registered: register state.
- `q_not`, output, WIDTH, combinational: always `~q`.
- `changed`, output, WIDTH, registered: bits of `q` that changed at the last edge.
- `sr_err`, output, 1, registered: sticky illegal-SR flag.
- `toggle_cnt`, output, CNT_W, registered: saturating count of bit transitions.

## Operation

**Per-bit next state when `en`=1** (bit i):
- JK: `j`/`k` = 00 hold; 01 → 0; 10 → 1; 11 → `~q[i]`.
- D: `q[i]` ← `j[i]`.
- T: `j[i]`=1 toggles the bit; 0 holds it.
- SR: `j`/`k` = 10 → 1; 01 → 0; 00 hold; 11 is illegal and holds the bit.

**Enable and mode**
- `en`=0: `q` holds regardless of `mode`, `j` and `k`.
- `mode` is sampled every edge, so a mode change takes effect at the same edge.

**Change mask and error flag**
- `changed` ← `q_next ^ q` at every edge where reset is not asserted. It is all zeros when `en`=0.
- `sr_err` sets at an edge where `en`=1, `mode`=11 and `|(j & k)`. It stays set until `clr_stat`.
- If set and clear occur at the same edge, set wins and `sr_err` = 1.

**Transition counter**
- `toggle_cnt` ← `toggle_cnt + popcount(changed)`, saturating at `2^CNT_W-1`. It never wraps.
- `clr_stat`=1: `toggle_cnt` ← 0, and that edge's increment is discarded.
- `clr_stat` does not affect `q` or `changed`.

**Reset** (`reset_n`=0 at an edge)
- Reset dominates `en`, `mode` and `clr_stat`.
- After the edge: `q`=`RESET_VALUE`, `q_not`=`~RESET_VALUE`, `changed`=0, `sr_err`=0, `toggle_cnt`=0.
- The reset load itself is not counted as a transition.
- Reset asserted mid-operation takes effect at the next edge. Any `changed` value in the counter pipeline is discarded.

## Timing

- `q`, `changed` and `sr_err`: 1-cycle latency from the inputs sampled at an edge. The new `q` and its `changed` mask become valid together.
- `q_not`: follows `q` combinationally, with no extra cycle.
- `toggle_cnt`: one cycle behind `changed`. A transition at edge N appears in `toggle_cnt` after edge N+1.
- Back-to-back updates are supported every cycle, with no stalls.
- No input is registered before use.

## Test plan

1. **Reset:** load `q`=0xA5, then hold `reset_n`=0 for one edge → `q`=0x00, `q_not`=0xFF, `changed`=0x00, `sr_err`=0, `toggle_cnt`=0. With `reset_n`=0 and `en`=1, `mode`=01, `j`=0xFF → `q` stays 0x00.
2. **JK mode:** from `q`=0x00, apply `j`=0xF0, `k`=0x0F → `q`=0xF0, `changed`=0xF0, and `toggle_cnt`=4 one cycle later. Then `j`=`k`=0xFF → `q`=0x0F, `changed`=0xFF, `toggle_cnt`=12. Then `j`=`k`=0x00 → `q` holds, `changed`=0x00.
3. **D/T modes:** in D mode with `j`=0x3C → `q`=0x3C, with `k` ignored even at 0xFF. Then T mode with `j`=0x81 → `q`=0xBD. Then `en`=0 with `j`=0xFF → `q`=0xBD, `changed`=0.
4. **SR illegal:** from `q`=0x00, SR mode with `j`=0x03, `k`=0x01 → bit0 holds at 0, bit1 sets, giving `q`=0x02, and `sr_err`=1. Then `clr_stat`=1 with a legal input → `sr_err`=0. Repeat with `clr_stat`=1 on the same edge as an illegal input → `sr_err`=1.
5. **Saturation** (`CNT_W`=4): toggle all 8 bits on two consecutive edges → `toggle_cnt`=8, then 15, and it stays at 15 on a third toggle. `clr_stat`=1 on an edge with `changed`=0xFF → `toggle_cnt`=0.
6. **Non-zero RESET_VALUE** (`RESET_VALUE`=0x5A): reset → `q`=0x5A, `q_not`=0xA5, `changed`=0, `toggle_cnt`=0. Assert reset mid-toggle stream → the counter freezes at 0 with no stale increment.
